// File: rtl/int_pkg.sv
// Shared encodings for the interrupt sequencer: source kinds, FSM states, vectors.
package int_pkg;

    localparam logic [1:0] KIND_IRQ = 2'b00;
    localparam logic [1:0] KIND_NMI = 2'b01;
    localparam logic [1:0] KIND_RST = 2'b10;

    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_RST = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

    typedef enum logic [1:0] {
        ST_RST_WAIT = 2'd0,
        ST_IDLE     = 2'd1,
        ST_SERVICE  = 2'd2
    } state_t;

    function automatic logic [15:0] kind_vec(input logic [1:0] k);
        case (k)
            KIND_NMI: return VEC_NMI;
            KIND_RST: return VEC_RST;
            default:  return VEC_IRQ;
        endcase
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for an asynchronous pin; resets to the inactive level (1).
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sh;

    always_ff @(posedge clk) begin
        if (reset) r_sh <= '1;
        else       r_sh <= {r_sh[STAGES-2:0], d};
    end

    assign q = r_sh[STAGES-1];

endmodule

// File: rtl/int_ctl.sv
// Interrupt sequencer: synchronizes irq_n/nmi_n, latches NMI edges, and arbitrates
// RESET > NMI > IRQ at instruction boundaries, holding the vector until ack.
module int_ctl import int_pkg::*; #(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq_n,
    input  logic        nmi_n,
    input  logic        sync,
    input  logic        I,
    input  logic        ack,
    output logic        take,
    output logic [15:0] vector,
    output logic [1:0]  kind,
    output logic        nmi_pend,
    output logic        ack_err
);

    localparam logic [3:0] TO_LAST = 4'(ACK_TIMEOUT - 1);

    logic       w_irq_s, w_nmi_s, w_irq_act, w_nmi_edge, w_nmi_clr;
    state_t     r_state, w_state_nxt;
    logic [1:0] r_kind, w_kind_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic       r_nmi_pend, r_nmi_prev, r_ack_err, w_ack_err_nxt;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_irq (
        .clk(clk), .reset(reset), .d(irq_n), .q(w_irq_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_nmi (
        .clk(clk), .reset(reset), .d(nmi_n), .q(w_nmi_s)
    );

    assign w_irq_act  = ~w_irq_s;
    assign w_nmi_edge = r_nmi_prev & ~w_nmi_s;
    assign w_nmi_clr  = (r_state == ST_SERVICE) & ack & (r_kind == KIND_NMI);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RST_WAIT;
            r_kind     <= KIND_RST;
            r_cnt      <= '0;
            r_nmi_pend <= 1'b0;
            r_nmi_prev <= 1'b1;
            r_ack_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_kind     <= w_kind_nxt;
            r_cnt      <= w_cnt_nxt;
            // A new edge outranks the ack that retires the previous NMI.
            r_nmi_pend <= w_nmi_edge | (r_nmi_pend & ~w_nmi_clr);
            r_nmi_prev <= w_nmi_s;
            r_ack_err  <= w_ack_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_kind_nxt    = r_kind;
        w_cnt_nxt     = r_cnt;
        w_ack_err_nxt = 1'b0;
        take          = 1'b0;
        vector        = VEC_IRQ;
        case (r_state)
            ST_RST_WAIT: begin
                vector = VEC_RST;
                take   = sync;
                if (sync) begin
                    w_kind_nxt  = KIND_RST;
                    w_state_nxt = ST_SERVICE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_IDLE: begin
                // BRK fetches through FFFE on its own, so IDLE parks the mux there.
                vector = VEC_IRQ;
                take   = sync & (r_nmi_pend | (w_irq_act & ~I));
                if (take) begin
                    w_kind_nxt  = r_nmi_pend ? KIND_NMI : KIND_IRQ;
                    w_state_nxt = ST_SERVICE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SERVICE: begin
                vector = kind_vec(r_kind);
                if (ack) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == TO_LAST) begin
                    w_ack_err_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: w_state_nxt = ST_RST_WAIT;
        endcase
    end

    assign kind     = r_kind;
    assign nmi_pend = r_nmi_pend;
    assign ack_err  = r_ack_err;

endmodule
